// File: rtl/fpnew_result_collector.sv
// Response collector behind the FP16 FMA unit: buffers {result, status, tag} in a
// small FIFO, re-presents it as a valid/ready stream, tracks credits and sticky fflags.
module fpnew_result_collector #(
  parameter int FLEN      = 16,
  parameter int TAG_WIDTH = 2,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_fire_i,
  output logic                 credit_ok_o,
  input  logic                 flush_i,
  input  logic                 fpu_valid_i,
  output logic                 fpu_ready_o,
  input  logic [FLEN-1:0]      fpu_result_i,
  input  logic [4:0]           fpu_status_i,
  input  logic [TAG_WIDTH-1:0] fpu_tag_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [FLEN-1:0]      resp_result_o,
  output logic [4:0]           resp_status_o,
  output logic [TAG_WIDTH-1:0] resp_tag_o,
  output logic [4:0]           fflags_o,
  input  logic                 fflags_clr_i,
  output logic [CNT_W-1:0]     inflight_o,
  output logic                 err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = FLEN + 5 + TAG_WIDTH;

  logic [EW-1:0]    mem_reg [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [CNT_W-1:0] inflight_reg;
  logic [4:0]       fflags_reg;
  logic             err_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic fire_ok;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign push    = fpu_valid_i & ~full;
  assign pop     = ~empty & resp_ready_i;
  assign fire_ok = issue_fire_i & credit_ok_o;

  assign credit_ok_o  = (inflight_reg < CNT_W'(DEPTH));
  assign fpu_ready_o  = ~full;
  assign resp_valid_o = ~empty;
  assign inflight_o   = inflight_reg;
  assign fflags_o     = fflags_reg;
  assign err_o        = err_reg;

  // The head comes straight out of the storage registers; a fresh write is only
  // visible once the write pointer has advanced, i.e. the following cycle.
  assign {resp_result_o, resp_status_o, resp_tag_o} = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push && !flush_i) begin
      mem_reg[wr_ptr_reg[AW-1:0]] <= {fpu_result_i, fpu_status_i, fpu_tag_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      inflight_reg <= '0;
    end else if (flush_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      inflight_reg <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_reg + {{AW{1'b0}}, push};
      rd_ptr_reg   <= rd_ptr_reg + {{AW{1'b0}}, pop};
      inflight_reg <= inflight_reg + {{(CNT_W-1){1'b0}}, fire_ok}
                                   - {{(CNT_W-1){1'b0}}, pop};
    end
  end

  // Clear wins over a same-cycle pop; a flushed pop contributes nothing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fflags_reg <= '0;
    end else if (fflags_clr_i) begin
      fflags_reg <= '0;
    end else if (pop && !flush_i) begin
      fflags_reg <= fflags_reg | resp_status_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_reg <= 1'b0;
    end else if ((issue_fire_i && !credit_ok_o) || (fpu_valid_i && full)) begin
      err_reg <= 1'b1;
    end
  end

endmodule
